// File: rtl/act_pkg.sv
// Shared definitions for the activation stream: mode encodings and the fixed-point 1.0 helper.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_RELU    = 2'b00,
    ACT_RELU_D  = 2'b01,
    ACT_LEAKY   = 2'b10,
    ACT_LEAKY_D = 2'b11
  } act_mode_e;

  function automatic int unsigned act_one(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

endpackage

// File: rtl/act_lane.sv
// Single-lane activation function (combinational).
// Leaky modes are built only when ACT_LEAKY_EN is defined; otherwise mode[1] is ignored.
module act_lane
  import act_pkg::*;
#(
  parameter int NBITS      = 16,
  parameter int FRAC       = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [NBITS-1:0] x,
  input  logic [1:0]       mode,
  output logic [NBITS-1:0] y
);

  localparam logic [NBITS-1:0] ONE = NBITS'(act_one(FRAC));

  logic neg;
  assign neg = x[NBITS-1];

`ifdef ACT_LEAKY_EN
  localparam logic [NBITS-1:0] LEAK_ONE = NBITS'(act_one(FRAC - LEAK_SHIFT));

  // Arithmetic shift floors toward negative infinity, which is the intended leak rounding.
  logic [NBITS-1:0] x_leak;
  assign x_leak = $unsigned($signed(x) >>> LEAK_SHIFT);

  always_comb begin
    y = '0;
    case (mode)
      ACT_RELU:   y = neg ? '0 : x;
      ACT_RELU_D: y = neg ? '0 : ONE;
      ACT_LEAKY:  y = neg ? x_leak : x;
      default:    y = neg ? LEAK_ONE : ONE;
    endcase
  end
`else
  localparam int unused_leak_shift = LEAK_SHIFT;
  logic unused_mode_hi;
  assign unused_mode_hi = mode[1];

  always_comb begin
    y = '0;
    if (!neg) y = mode[0] ? ONE : x;
  end
`endif

endmodule

// File: rtl/act_stream.sv
// Two-stage valid/ready activation pipeline with a saturating zero-output counter.
// Optional leaky modes are enabled by defining ACT_LEAKY_EN.
module act_stream
  import act_pkg::*;
#(
  parameter int NBITS      = 16,
  parameter int FRAC       = 8,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNTW       = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*NBITS-1:0] in_data,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*NBITS-1:0] out_data,
  input  logic                   cnt_clr,
  output logic [CNTW-1:0]        zero_cnt
);

  localparam int W  = LANES * NBITS;
  localparam int ZW = $clog2(LANES + 1);

  logic           s1_v_q, s1_v_d;
  logic [W-1:0]   s1_data_q, s1_data_d;
  logic [1:0]     s1_mode_q, s1_mode_d;
  logic           s2_v_q, s2_v_d;
  logic [W-1:0]   s2_data_q, s2_data_d;
  logic [CNTW-1:0] zero_cnt_q, zero_cnt_d;

  logic           s1_adv, s2_adv, out_hs;
  logic [W-1:0]   lane_y;
  logic [LANES-1:0] lane_zero;
  logic [ZW-1:0]  zeros;
  logic [CNTW:0]  cnt_sum;

  assign s2_adv    = !s2_v_q || out_ready;
  assign s1_adv    = !s1_v_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign zero_cnt  = zero_cnt_q;
  assign out_hs    = s2_v_q && out_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      act_lane #(
        .NBITS      (NBITS),
        .FRAC       (FRAC),
        .LEAK_SHIFT (LEAK_SHIFT)
      ) u_lane (
        .x    (s1_data_q[gi*NBITS +: NBITS]),
        .mode (s1_mode_q),
        .y    (lane_y[gi*NBITS +: NBITS])
      );
      assign lane_zero[gi] = (s2_data_q[gi*NBITS +: NBITS] == '0);
    end
  endgenerate

  always_comb begin
    zeros = '0;
    for (int i = 0; i < LANES; i++) zeros = zeros + ZW'(lane_zero[i]);
  end

  assign cnt_sum = {1'b0, zero_cnt_q} + (CNTW+1)'(zeros);

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_mode_d = s1_mode_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    zero_cnt_d = zero_cnt_q;

    if (s1_adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_mode_d = in_mode;
      end
    end

    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) s2_data_d = lane_y;
    end

    // A clear that lands on a handshake keeps that beat's zeros rather than dropping them.
    if (cnt_clr)     zero_cnt_d = out_hs ? CNTW'(zeros) : '0;
    else if (out_hs) zero_cnt_d = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= '0;
      s2_v_q     <= 1'b0;
      s2_data_q  <= '0;
      zero_cnt_q <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_v_q     <= s2_v_d;
      s2_data_q  <= s2_data_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

endmodule

// File: tb/tb_act_stream.sv
// Self-checking bench for act_stream: fixed vectors, random streams with backpressure, zero counter.
module tb_act_stream;

  localparam int NB = 16;
  localparam int LN = 4;
  localparam int W  = NB * LN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    in_mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          cnt_clr = 1'b0;
  logic [23:0]   zero_cnt;
  logic [3:0]    sat_zero_cnt;
  logic          unused_sat_in_ready;
  logic          unused_sat_out_valid;
  logic [W-1:0]  unused_sat_out_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  act_stream dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cnt_clr(cnt_clr), .zero_cnt(zero_cnt)
  );

  act_stream #(.CNTW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(unused_sat_in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(unused_sat_out_valid), .out_ready(out_ready), .out_data(unused_sat_out_data),
    .cnt_clr(cnt_clr), .zero_cnt(sat_zero_cnt)
  );

  // Reference: activation computed with signed integer arithmetic at Q8.8, leak slope 1/8.
  function automatic logic [15:0] ref_lane(input logic [15:0] x, input logic [1:0] mode);
    int v;
    int r;
    logic [1:0] m;
    v = $signed(x);
    m = mode;
`ifndef ACT_LEAKY_EN
    m[1] = 1'b0;
`endif
    case (m)
      2'd0:    r = (v < 0) ? 0 : v;
      2'd1:    r = (v < 0) ? 0 : 256;
      2'd2:    r = (v < 0) ? -((-v + 7) / 8) : v;
      default: r = (v < 0) ? 32 : 256;
    endcase
    return r[15:0];
  endfunction

  function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d, input logic [1:0] mode);
    logic [W-1:0] r;
    for (int i = 0; i < LN; i++) r[i*NB +: NB] = ref_lane(d[i*NB +: NB], mode);
    return r;
  endfunction

  function automatic int count_zero_lanes(input logic [W-1:0] d);
    int n = 0;
    for (int i = 0; i < LN; i++) if (d[i*NB +: NB] == 16'h0000) n++;
    return n;
  endfunction

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] d;
    for (int i = 0; i < LN; i++)
      d[i*NB +: NB] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
    return d;
  endfunction

  // Drives one cycle of inputs at the falling edge and samples the DUT just before the rising edge.
  task automatic drive_cycle(input bit iv, input logic [W-1:0] d, input logic [1:0] m,
                             input bit ordy, input bit clr,
                             output bit ihs, output bit ohs, output bit ovld,
                             output logic [W-1:0] od, output bit irdy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    cnt_clr   = clr;
    #4;
    irdy = in_ready;
    ovld = out_valid;
    od   = out_data;
    ihs  = iv && in_ready;
    ohs  = out_valid && ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit ihs, ohs, ovld, irdy;
    logic [W-1:0] od;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 2'b00, 1'b1, 1'b0, ihs, ohs, ovld, od, irdy);
  endtask

  task automatic test_reset();
    bit ihs, ohs, ovld, irdy;
    logic [W-1:0] od;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || zero_cnt !== 24'd0 || in_ready !== 1'b1 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_init: got valid=%b cnt=%0d rdy=%b data=%h want 0/0/1/0",
               out_valid, zero_cnt, in_ready, out_data);
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, '0, 2'b00, 1'b1, 1'b0, ihs, ohs, ovld, od, irdy);
    idle(3);
    vectors++;
    if (zero_cnt !== 24'd12) begin
      miscompares++;
      $display("FAIL reset_precount: got %0d want 12", zero_cnt);
    end
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, {16'h0100, 16'h0200, 16'h0300, 16'h0400}, 2'b00, 1'b0, 1'b0, ihs, ohs, ovld, od, irdy);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || zero_cnt !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_async: got valid=%b cnt=%0d want 0/0", out_valid, zero_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || zero_cnt !== 24'd0 || in_ready !== 1'b1 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got valid=%b cnt=%0d rdy=%b data=%h want 0/0/1/0",
               out_valid, zero_cnt, in_ready, out_data);
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, '0, 2'b00, 1'b1, 1'b0, ihs, ohs, ovld, od, irdy);
      vectors++;
      if (ovld !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_no_stale: cycle %0d got out_valid=%b data=%h want 0", i, ovld, od);
      end
    end
  endtask

  task automatic test_fixed(input logic [1:0] mode, input logic [W-1:0] expected);
    bit ihs, ohs, ovld, irdy;
    logic [W-1:0] od;
    logic [W-1:0] vec;
    vec = {16'h7FFF, 16'h0000, 16'hFF00, 16'h0180};
    drive_cycle(1'b1, vec, mode, 1'b1, 1'b0, ihs, ohs, ovld, od, irdy);
    vectors++;
    if (ihs !== 1'b1) begin
      miscompares++;
      $display("FAIL fixed_accept mode %0d: got in_ready=%b want 1", mode, irdy);
    end
    drive_cycle(1'b0, '0, 2'b00, 1'b1, 1'b0, ihs, ohs, ovld, od, irdy);
    vectors++;
    if (ovld !== 1'b0) begin
      miscompares++;
      $display("FAIL fixed_early mode %0d: got out_valid=%b one cycle after accept want 0", mode, ovld);
    end
    drive_cycle(1'b0, '0, 2'b00, 1'b1, 1'b0, ihs, ohs, ovld, od, irdy);
    vectors++;
    if (ovld !== 1'b1 || od !== expected) begin
      miscompares++;
      $display("FAIL fixed_result mode %0d: got valid=%b data=%h want 1 %h", mode, ovld, od, expected);
    end
  endtask

  task automatic test_back_to_back();
    bit ihs, ohs, ovld, irdy;
    logic [W-1:0] od, nd, exp_d;
    logic [1:0] nm;
    logic [W-1:0] q[$];
    int sent = 0, got = 0, zexp = 0;
    drive_cycle(1'b0, '0, 2'b00, 1'b1, 1'b1, ihs, ohs, ovld, od, irdy);
    nd = rand_beat();
    nm = 2'($urandom);
    for (int c = 0; c < 60 && got < 24; c++) begin
      drive_cycle(sent < 24, nd, nm, 1'b1, 1'b0, ihs, ohs, ovld, od, irdy);
      if (sent < 24) begin
        vectors++;
        if (!irdy) begin
          miscompares++;
          $display("FAIL b2b_throughput: cycle %0d got in_ready=0 want 1", c);
        end
      end
      if (ihs) begin
        q.push_back(ref_beat(nd, nm));
        sent++;
        nd = rand_beat();
        nm = 2'($urandom);
      end
      if (ohs) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 'x;
        vectors++;
        if (od !== exp_d) begin
          miscompares++;
          $display("FAIL b2b_data: beat %0d got %h want %h", got, od, exp_d);
        end
        zexp += count_zero_lanes(exp_d);
        got++;
      end
    end
    vectors++;
    if (got != 24) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d beats want 24", got);
    end
    vectors++;
    if (zero_cnt !== 24'(zexp)) begin
      miscompares++;
      $display("FAIL b2b_zero_cnt: got %0d want %0d", zero_cnt, zexp);
    end
  endtask

  task automatic test_backpressure();
    bit ihs, ohs, ovld, irdy, ordy, prev_stall;
    logic [W-1:0] od, nd, exp_d, prev_od;
    logic [W-1:0] q[$];
    int sent = 0, got = 0, occ = 0;
    prev_stall = 1'b0;
    prev_od = '0;
    nd = rand_beat();
    for (int c = 0; c < 300 && got < 8; c++) begin
      ordy = ($urandom_range(0, 9) >= 4);
      drive_cycle(sent < 8, nd, 2'(sent), ordy, 1'b0, ihs, ohs, ovld, od, irdy);
      vectors++;
      if (irdy !== !(occ == 2 && !ordy)) begin
        miscompares++;
        $display("FAIL bp_in_ready: cycle %0d got %b want %b (occupancy %0d, out_ready %b)",
                 c, irdy, !(occ == 2 && !ordy), occ, ordy);
      end
      if (prev_stall) begin
        vectors++;
        if (ovld !== 1'b1 || od !== prev_od) begin
          miscompares++;
          $display("FAIL bp_stable: cycle %0d got valid=%b data=%h want 1 %h", c, ovld, od, prev_od);
        end
      end
      if (ihs) begin
        q.push_back(ref_beat(nd, 2'(sent)));
        sent++;
        nd = rand_beat();
      end
      if (ohs) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 'x;
        vectors++;
        if (od !== exp_d) begin
          miscompares++;
          $display("FAIL bp_data: beat %0d got %h want %h", got, od, exp_d);
        end
        got++;
      end
      occ = occ + int'(ihs) - int'(ohs);
      prev_stall = ovld && !ordy;
      prev_od = od;
    end
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL bp_count: got %0d beats want 8", got);
    end
  endtask

  task automatic test_zero_cnt();
    bit ihs, ohs, ovld, irdy;
    logic [W-1:0] od, d;
    int p0, p1;
    drive_cycle(1'b0, '0, 2'b00, 1'b1, 1'b1, ihs, ohs, ovld, od, irdy);
    vectors++;
    if (zero_cnt !== 24'd0) begin
      miscompares++;
      $display("FAIL zc_clear: got %0d want 0", zero_cnt);
    end
    for (int b = 0; b < 3; b++) begin
      p0 = $urandom_range(0, 3);
      p1 = (p0 + $urandom_range(1, 3)) % 4;
      for (int i = 0; i < LN; i++)
        d[i*NB +: NB] = (i == p0 || i == p1) ? (16'h8000 | 16'($urandom_range(0, 16'h7FFF)))
                                             : 16'($urandom_range(1, 16'h7FFF));
      drive_cycle(1'b1, d, 2'b00, 1'b1, 1'b0, ihs, ohs, ovld, od, irdy);
    end
    idle(2);
    vectors++;
    if (zero_cnt !== 24'd6) begin
      miscompares++;
      $display("FAIL zc_three_beats: got %0d want 6", zero_cnt);
    end
    drive_cycle(1'b1, {16'h0123, 16'h0000, 16'h7000, 16'h0001}, 2'b00, 1'b1, 1'b0, ihs, ohs, ovld, od, irdy);
    drive_cycle(1'b0, '0, 2'b00, 1'b1, 1'b0, ihs, ohs, ovld, od, irdy);
    drive_cycle(1'b0, '0, 2'b00, 1'b1, 1'b1, ihs, ohs, ovld, od, irdy);
    vectors++;
    if (ohs !== 1'b1 || zero_cnt !== 24'd1) begin
      miscompares++;
      $display("FAIL zc_clear_on_beat: got handshake=%b cnt=%0d want 1 1", ohs, zero_cnt);
    end
  endtask

  task automatic test_saturation();
    bit ihs, ohs, ovld, irdy;
    logic [W-1:0] od;
    drive_cycle(1'b0, '0, 2'b00, 1'b1, 1'b1, ihs, ohs, ovld, od, irdy);
    for (int b = 0; b < 5; b++) drive_cycle(1'b1, '0, 2'b00, 1'b1, 1'b0, ihs, ohs, ovld, od, irdy);
    idle(2);
    vectors++;
    if (zero_cnt !== 24'd20 || sat_zero_cnt !== 4'd15) begin
      miscompares++;
      $display("FAIL sat_hold: got wide=%0d narrow=%0d want 20 15", zero_cnt, sat_zero_cnt);
    end
    drive_cycle(1'b1, {16'h0000, 16'h0000, 16'h8001, 16'h0005}, 2'b00, 1'b1, 1'b0, ihs, ohs, ovld, od, irdy);
    idle(2);
    vectors++;
    if (zero_cnt !== 24'd23 || sat_zero_cnt !== 4'd15) begin
      miscompares++;
      $display("FAIL sat_no_wrap: got wide=%0d narrow=%0d want 23 15", zero_cnt, sat_zero_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_fixed(2'b00, {16'h7FFF, 16'h0000, 16'h0000, 16'h0180});
    test_fixed(2'b01, {16'h0100, 16'h0100, 16'h0000, 16'h0100});
`ifdef ACT_LEAKY_EN
    test_fixed(2'b10, {16'h7FFF, 16'h0000, 16'hFFE0, 16'h0180});
    test_fixed(2'b11, {16'h0100, 16'h0100, 16'h0020, 16'h0100});
`else
    test_fixed(2'b10, {16'h7FFF, 16'h0000, 16'h0000, 16'h0180});
    test_fixed(2'b11, {16'h0100, 16'h0100, 16'h0000, 16'h0100});
`endif
    test_back_to_back();
    test_backpressure();
    test_zero_cnt();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
